curl_mwm_checker: RTL and testbench

//  Downstream consumer of the curl_transform state after a transform completes.

---
 rtl/curl_mwm_checker.sv | 141 ++++++++++++++
 tb/tb_curl_mwm_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/curl_mwm_checker.sv
// Scans the 243-trit curl hash from trit 242 downward, counting leading zero trits,
// and compares the run against a latched min-weight-magnitude.
module curl_mwm_checker #(
  parameter int TRITS_PER_WORD = 27,
  parameter int HASH_WORDS     = 9,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic                        i_start,
  input  logic [CNT_WIDTH-1:0]        i_mwm,
  output logic [3:0]                  o_curl_addr,
  output logic                        o_curl_re,
  input  logic [2*TRITS_PER_WORD-1:0] i_curl_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic [CNT_WIDTH-1:0]        o_zero_cnt,
  output logic                        o_bad_trit
);

  localparam int NW = $clog2(TRITS_PER_WORD + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_TRITS = CNT_WIDTH'(TRITS_PER_WORD * HASH_WORDS);
  localparam logic [NW-1:0]        FULL_WORD = NW'(TRITS_PER_WORD);
  localparam logic [3:0]           TOP_ADDR  = 4'(HASH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, CHK, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           addr_q, addr_d;
  logic [CNT_WIDTH-1:0] mwm_q, mwm_d;
  logic [CNT_WIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic                 pass_q, pass_d;
  logic                 bad_q, bad_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 re_q, re_d;

  logic [NW-1:0]        lead_n;
  logic                 word_bad;
  logic [CNT_WIDTH-1:0] sum;

  // Leading-zero field count from the top field down; an illegal 2'b10 ends the run.
  always_comb begin
    logic       seen_nz;
    logic [1:0] field;
    lead_n   = '0;
    word_bad = 1'b0;
    seen_nz  = 1'b0;
    field    = 2'b00;
    for (int i = TRITS_PER_WORD - 1; i >= 0; i--) begin
      field = i_curl_data[2*i +: 2];
      if (field == 2'b10) word_bad = 1'b1;
      if (field != 2'b00) seen_nz = 1'b1;
      else if (!seen_nz) lead_n = lead_n + NW'(1);
    end
  end

  assign sum = zero_cnt_q + CNT_WIDTH'(lead_n);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mwm_d      = mwm_q;
    zero_cnt_d = zero_cnt_q;
    pass_d     = pass_q;
    bad_d      = bad_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          mwm_d      = (i_mwm > MAX_TRITS) ? MAX_TRITS : i_mwm;
          zero_cnt_d = '0;
          pass_d     = 1'b0;
          bad_d      = 1'b0;
          busy_d     = 1'b1;
          if (mwm_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = RD;
            addr_d  = TOP_ADDR;
          end
        end
      end
      RD: state_d = CHK;
      CHK: begin
        zero_cnt_d = sum;
        bad_d      = bad_q | word_bad;
        if (lead_n < FULL_WORD || sum >= mwm_q || addr_q == 4'd0) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q - 4'd1;
          state_d = RD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (zero_cnt_q >= mwm_q);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobe is registered, so it is raised on entry to RD.
    re_d = (state_d == RD);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mwm_q      <= '0;
      zero_cnt_q <= '0;
      pass_q     <= 1'b0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mwm_q      <= mwm_d;
      zero_cnt_q <= zero_cnt_d;
      pass_q     <= pass_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      re_q       <= re_d;
    end
  end

  assign o_curl_addr = addr_q;
  assign o_curl_re   = re_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_zero_cnt  = zero_cnt_q;
  assign o_bad_trit  = bad_q;

endmodule

// File: tb/tb_curl_mwm_checker.sv
// Directed bench for curl_mwm_checker: a small curl state memory answers reads one
// cycle later, and expected results queued at start are compared on o_done.
module tb_curl_mwm_checker;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_start;
  logic [7:0]  i_mwm;
  logic [3:0]  o_curl_addr;
  logic        o_curl_re;
  logic [53:0] i_curl_data;
  logic        o_busy, o_done, o_pass, o_bad_trit;
  logic [7:0]  o_zero_cnt;

  logic [53:0] mem [0:15];

  typedef struct {
    int cnt;
    int pass;
    int bad;
    int cyc;
    int nreads;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  curl_mwm_checker dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_start     (i_start),
    .i_mwm       (i_mwm),
    .o_curl_addr (o_curl_addr),
    .o_curl_re   (o_curl_re),
    .i_curl_data (i_curl_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_zero_cnt  (o_zero_cnt),
    .o_bad_trit  (o_bad_trit)
  );

  always #5 i_clk = ~i_clk;

  // Curl read port: data valid one cycle after the strobe.
  always @(posedge i_clk) begin
    if (o_curl_re) i_curl_data <= mem[o_curl_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  // One check: queue the expectation, pulse start, follow the scan to o_done.
  // poke_cyc >= 0 raises a second i_start (mwm 0) sampled at the following edge.
  task automatic run_check(input string name, input int mwm, input int poke_cyc,
                           input int e_cnt, input int e_pass, input int e_bad,
                           input int e_cyc, input int e_reads);
    exp_t e;
    int   cyc;
    int   reads[$];
    e.cnt = e_cnt; e.pass = e_pass; e.bad = e_bad; e.cyc = e_cyc; e.nreads = e_reads;
    exp_q.push_back(e);
    @(negedge i_clk);
    i_mwm   = mwm[7:0];
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    cyc = 0;
    forever begin
      if (o_curl_re) reads.push_back(int'(o_curl_addr));
      if (o_done || cyc >= 60) break;
      i_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) i_mwm = 8'd0;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      cyc++;
    end
    e = exp_q.pop_front();
    $display("%s: mwm=%0d done_cycle=%0d reads=%0d zero_cnt=%0d pass=%0d bad=%0d",
             name, mwm, cyc, reads.size(), o_zero_cnt, o_pass, o_bad_trit);
    check({name, " done"}, 32'(o_done), 32'd1);
    check({name, " cycle"}, 32'(cyc), 32'(e.cyc));
    check({name, " zero_cnt"}, 32'(o_zero_cnt), 32'(e.cnt));
    check({name, " pass"}, 32'(o_pass), 32'(e.pass));
    check({name, " bad"}, 32'(o_bad_trit), 32'(e.bad));
    check({name, " busy_at_done"}, 32'(o_busy), 32'd0);
    check({name, " nreads"}, 32'(reads.size()), 32'(e.nreads));
    for (int i = 0; i < reads.size() && i < e.nreads; i++)
      check({name, " read_addr"}, 32'(reads[i]), 32'(8 - i));
    @(posedge i_clk);
    #1;
    check({name, " done_pulse"}, 32'(o_done), 32'd0);
    check({name, " busy_after"}, 32'(o_busy), 32'd0);
    check({name, " hold_cnt"}, 32'(o_zero_cnt), 32'(e.cnt));
    check({name, " hold_pass"}, 32'(o_pass), 32'(e.pass));
    if (e.nreads > 0) check({name, " hold_addr"}, 32'(o_curl_addr), 32'(9 - e.nreads));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"}, 32'(o_busy), 32'd0);
    check({name, " done"}, 32'(o_done), 32'd0);
    check({name, " pass"}, 32'(o_pass), 32'd0);
    check({name, " zero_cnt"}, 32'(o_zero_cnt), 32'd0);
    check({name, " bad"}, 32'(o_bad_trit), 32'd0);
    check({name, " re"}, 32'(o_curl_re), 32'd0);
    check({name, " addr"}, 32'(o_curl_addr), 32'd0);
  endtask

  initial begin
    int saw_done;
    i_arst      = 1'b1;
    i_start     = 1'b0;
    i_mwm       = '0;
    i_curl_data = '0;
    clear_mem();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_arst = 1'b0;
    #1;
    check_all_zero("reset");
    $display("reset: outputs checked after release");

    // T1
    run_check("T1", 14, -1, 27, 1, 0, 3, 1);
    // T2: field 14 (bits 29:28) = +1
    mem[8] = 54'h1 << 28;
    run_check("T2", 14, -1, 12, 0, 0, 3, 1);
    // T3
    clear_mem();
    run_check("T3", 243, -1, 243, 1, 0, 19, 9);
    // T4
    run_check("T4_mwm0", 0, -1, 0, 1, 0, 1, 0);
    run_check("T4_clamp", 250, -1, 243, 1, 0, 19, 9);
    // T5
    mem[8] = 54'h2 << 52;
    run_check("T5_illegal", 14, -1, 0, 0, 1, 3, 1);
    mem[8] = '0;
    mem[7] = 54'h3 << 52;
    run_check("T5_neg", 30, -1, 27, 0, 0, 5, 2);
    // T6: start mid-scan ignored, start in DONE cycle ignored
    clear_mem();
    run_check("T6_busy_start", 243, 4, 243, 1, 0, 19, 9);
    run_check("T6_done_start", 14, 2, 27, 1, 0, 3, 1);

    // T6: reset at cycle 6 of a full scan
    @(negedge i_clk);
    i_mwm   = 8'd243;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    #1;
    check("T6_rst pre_busy", 32'(o_busy), 32'd1);
    i_arst = 1'b1;
    #1;
    check_all_zero("T6_rst");
    saw_done = 0;
    repeat (2) begin
      @(posedge i_clk);
      #1;
      if (o_done) saw_done = 1;
    end
    @(negedge i_clk);
    i_arst = 1'b0;
    repeat (25) begin
      @(posedge i_clk);
      #1;
      if (o_done) saw_done = 1;
    end
    check("T6_rst no_done", 32'(saw_done), 32'd0);
    check("T6_rst idle_busy", 32'(o_busy), 32'd0);
    $display("T6_rst: reset at cycle 6, no done pulse seen=%0d", saw_done);
    run_check("T6_after_rst", 14, -1, 27, 1, 0, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
